input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Front-end conditioner for board switches and push-buttons; drives the clean logic inputs of the gate-level circuits, such as the gate inputs fed from slide switches.
- Per channel: synchronises the asynchronous raw pin, then debounces it with a stability counter.
- Outputs a clean level plus one-cycle rise and fall pulses.
- Sits between the top-level pin constraints and any combinational or sequential logic that consumes switch or button levels.

Parameters:
N_CH, 2, number of independent input channels (>=1)
STABLE_CYCLES, 16, consecutive identical synchronised samples required to accept a new level (>=2)
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
raw_in  input  N_CH  asynchronous raw switch/button pins
level_out  output  N_CH  debounced level per channel
rise_pulse  output  N_CH  one-cycle pulse when level_out goes 0->1
fall_pulse  output  N_CH  one-cycle pulse when level_out goes 1->0
toggle_out  output  N_CH  toggle state per channel (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; synchronous active-high reset `rst`. Every flop updates only on the rising edge of clk.
- Reset (rst=1 at an edge):
  - all synchroniser flops, level_out, rise_pulse, fall_pulse, toggle_out and counters go to 0;
  - every channel FSM goes to IDLE_LOW.
- Channels are fully independent. No cross-channel interaction.
- Synchroniser: SYNC_STAGES-deep shift chain; its last stage is `s`.
- Per-channel FSM states:
  - IDLE_LOW: level=0. If s=1, go to WAIT_HIGH with cnt=1; else stay.
  - WAIT_HIGH: level=0. If s=0, return to IDLE_LOW with cnt=0 (glitch rejected, no pulse). If s=1 and cnt==STABLE_CYCLES-1, go to IDLE_HIGH, set level=1, assert rise for 1 cycle. Otherwise cnt+=1.
  - IDLE_HIGH: level=1. If s=0, go to WAIT_LOW with cnt=1.
  - WAIT_LOW: mirror of WAIT_HIGH. Accepting the new level sets level=0 and asserts fall.
- Counter width is $clog2(STABLE_CYCLES+1). cnt never exceeds STABLE_CYCLES-1, so no wrap-around.
- Latency: raw_in changes and stays stable. With the edge that first samples the change numbered edge 1, level_out and the pulse are visible after edge SYNC_STAGES+STABLE_CYCLES.
- rise_pulse and fall_pulse:
  - registered;
  - high for exactly one cycle;
  - never both high on the same channel;
  - never high during or on the edge immediately after reset.
- A bounce shorter than STABLE_CYCLES samples produces no level change and no pulse. Debounce restarts from cnt=1 on the next differing sample.
- Reset asserted mid-WAIT: the transition is aborted, with no pulse. After reset the FSM re-acquires from IDLE_LOW. If raw is held high, the rise follows SYNC_STAGES+STABLE_CYCLES edges after rst deasserts.

Optional Feature:
- Macro: INPUT_COND_TOGGLE_EN.
- Defined: toggle_out[i] is a register that inverts on each cycle rise_pulse[i]=1, so a push-button acts as an on/off switch. Reset value is 0.
- Not defined: toggle_out is tied to constant 0 and no toggle flops are synthesised. All other behaviour is identical.

Decomposition:
- Package input_cond_pkg holds:
  - the per-channel state enum (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW) as a 2-bit typedef;
  - default constants DEF_STABLE_CYCLES=16 and DEF_SYNC_STAGES=2.
- Sub-module debounce_channel:
  - contains one channel's synchroniser, FSM, counter, pulses and optional toggle;
  - input_conditioner instantiates it N_CH times in a generate loop.

Test Plan:
All scenarios use N_CH=2, STABLE_CYCLES=4, SYNC_STAGES=2.
1. Reset, then raw_in=2'b01 held -> level_out=2'b01 after edge 6 (edge 1 = first sampling edge); rise_pulse=2'b01 for exactly that one cycle; fall_pulse stays 0.
2. raw_in[0] high 3 cycles, then low -> level_out[0] stays 0; no pulses; FSM back in IDLE_LOW.
3. From level 1, raw_in[1] bounces 0,1,0,1 then holds 0 -> fall_pulse[1] fires once, 6 edges after the final 1->0 sample; no rise_pulse.
4. Both channels rise on the same edge -> both pulses are simultaneous and identical; channel 0 then bounces without affecting channel 1.
5. rst asserted for 1 cycle while channel 0 is in WAIT_HIGH with cnt=2 -> no pulse; all outputs are 0 after the reset edge; with raw still high, the rise occurs 6 edges after rst deasserts.
6. With INPUT_COND_TOGGLE_EN: three debounced presses on channel 0 -> toggle_out[0] goes 1,0,1. Without the macro -> toggle_out stays 2'b00.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the switch/button input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } ch_state_t;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES   = 2;

  // A WAIT state still presents the level it is trying to leave.
  function automatic logic state_level(input ch_state_t st);
    return (st == IDLE_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One channel: synchroniser, debounce FSM with stability counter, edge pulses.
// Optional toggle register enabled by INPUT_COND_TOGGLE_EN.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronised sample -> debounce FSM
  ch_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, rise_d, fall_d;
  logic          level_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = state_level(state_d);
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (state_q == WAIT_HIGH && s && cnt_q == CNT_LAST) rise_d = 1'b1;
    if (state_q == WAIT_LOW && !s && cnt_q == CNT_LAST) fall_d = 1'b1;
  end

  // FSM decisions -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef INPUT_COND_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk) begin
    if (rst)         toggle_q <= 1'b0;
    else if (rise_q) toggle_q <= ~toggle_q;
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel debounced front end for switches and push-buttons.
// Define INPUT_COND_TOGGLE_EN to turn each channel's rise pulse into an on/off toggle.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[g]),
      .level (level_out[g]),
      .rise  (rise_pulse[g]),
      .fall  (fall_pulse[g]),
      .toggle(toggle_out[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with N_CH=2, STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_input_conditioner;

  localparam int N_CH          = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int SYNC_STAGES   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out, rise_pulse, fall_pulse, toggle_out;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_CH         (N_CH),
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  typedef struct {
    int         edge_no;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] tog;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         done = 0;
  logic [1:0] exp_lvl = 2'b00;
  logic [1:0] exp_tog = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs are keyed by the edge number after which they must be visible.
  task automatic push(input int e, input logic [1:0] lvl, input logic [1:0] r,
                      input logic [1:0] f, input logic [1:0] t);
    exp_t x;
    int   i;
    x.edge_no = e; x.lvl = lvl; x.rise = r; x.fall = f; x.tog = t;
    i = 0;
    while (i < sb.size() && sb[i].edge_no <= e) i++;
    sb.insert(i, x);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // raw_in already holds nxt, first sampled at edge k+1; new level lands at edge k+6.
  task automatic settle(input int k, input logic [1:0] nxt);
    logic [1:0] r, f;
    r = nxt & ~exp_lvl;
    f = exp_lvl & ~nxt;
    push(k + 5, exp_lvl, 2'b00, 2'b00, exp_tog);
    push(k + 6, nxt, r, f, exp_tog);
`ifdef INPUT_COND_TOGGLE_EN
    exp_tog = exp_tog ^ r;
`endif
    push(k + 7, nxt, 2'b00, 2'b00, exp_tog);
    exp_lvl = nxt;
  endtask

  task automatic drive_and_settle(input logic [1:0] nxt);
    raw_in = nxt;
    settle(cyc, nxt);
    step(8);
  endtask

  initial begin
    int k;
    rst    = 1'b1;
    raw_in = 2'b00;
    step(2);
    push(cyc, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    push(cyc + 1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 3-sample glitch on ch0 is rejected
    k = cyc;
    raw_in = 2'b01;
    step(3);
    raw_in = 2'b00;
    push(k + 6, 2'b00, 2'b00, 2'b00, exp_tog);
    push(k + 9, 2'b00, 2'b00, 2'b00, exp_tog);
    step(10);

    // Clean rise on ch0
    drive_and_settle(2'b01);

    // ch1 high, then bounce 0,1,0,1 and hold 0
    drive_and_settle(2'b11);
    raw_in = 2'b01; step(1);
    raw_in = 2'b11; step(1);
    raw_in = 2'b01; step(1);
    raw_in = 2'b11; step(1);
    raw_in = 2'b01;
    settle(cyc, 2'b01);
    step(8);

    // Simultaneous rise, then ch0 bounce that leaves ch1 untouched
    drive_and_settle(2'b00);
    drive_and_settle(2'b11);
    k = cyc;
    raw_in = 2'b10;
    step(2);
    raw_in = 2'b11;
    push(k + 7, 2'b11, 2'b00, 2'b00, exp_tog);
    push(k + 10, 2'b11, 2'b00, 2'b00, exp_tog);
    step(10);
    drive_and_settle(2'b10);

    // Reset while ch0 is in WAIT_HIGH with cnt=2
    drive_and_settle(2'b00);
    raw_in = 2'b01;
    step(4);
    rst = 1'b1;
    step(1);
    exp_lvl = 2'b00;
    exp_tog = 2'b00;
    push(cyc, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    settle(cyc, 2'b01);
    step(8);

    // Three presses on ch0
    drive_and_settle(2'b00);
    for (int p = 0; p < 3; p++) begin
      drive_and_settle(2'b01);
      drive_and_settle(2'b00);
    end

    done = 1'b1;
    step(4);
  end

  initial begin
    exp_t x;
    bit   matched;
    forever begin
      @(negedge clk);
      if (done) begin
        while (sb.size() > 0) begin
          x = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL never_checked edge=%0d (simulation ended at edge %0d)", x.edge_no, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      matched = 1'b0;
      while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.edge_no < cyc) begin
          errors++;
          $display("FAIL stale_entry edge=%0d now=%0d", x.edge_no, cyc);
        end else begin
          matched = 1'b1;
          if (level_out !== x.lvl || rise_pulse !== x.rise || fall_pulse !== x.fall ||
              toggle_out !== x.tog) begin
            errors++;
            $display("FAIL outputs edge=%0d got lvl=%b rise=%b fall=%b tog=%b want lvl=%b rise=%b fall=%b tog=%b",
                     cyc, level_out, rise_pulse, fall_pulse, toggle_out,
                     x.lvl, x.rise, x.fall, x.tog);
          end
        end
      end
      if (!matched) begin
        checks++;
        if ((rise_pulse | fall_pulse) !== 2'b00) begin
          errors++;
          $display("FAIL unexpected_pulse edge=%0d got rise=%b fall=%b want rise=00 fall=00",
                   cyc, rise_pulse, fall_pulse);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1);
  end

endmodule
